// File: rtl/uart_rx_ovs_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding, FIFO entry layout
// and the majority-vote helper.
package uart_rx_ovs_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] DATA_REG_DFT = 8'h00;

  // Entry layout: {break, frame, parity, data[7:0]}
  localparam int unsigned ENT_DATA = 0;
  localparam int unsigned ENT_PAR  = 8;
  localparam int unsigned ENT_FRM  = 9;
  localparam int unsigned ENT_BRK  = 10;
  localparam int unsigned ENT_W    = 11;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; the read port shows zero when empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr_q];

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: synchroniser, sample-tick detect, 3-sample vote, framing FSM
// and a receive FIFO drained through valid/ready.
module uart_rx_ovs
  import uart_rx_ovs_pkg::*;
#(
  parameter int unsigned OSR        = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_clk,
  input  logic       rx_en,
  input  logic [1:0] data_len,
  input  logic       no_parity,
  input  logic       ev_parity,
  input  logic       stop2,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(OSR);
  localparam logic [CW-1:0] CNT_MAX = CW'(OSR - 1);
  localparam logic [CW-1:0] S0      = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] S1      = CW'(OSR / 2);
  localparam logic [CW-1:0] S2      = CW'(OSR / 2 + 1);
  localparam logic [CW-1:0] SV      = CW'(OSR / 2 + 2);

  logic rxd_s1_q, rxd_s2_q, rxd_last_q, sclk_q, tick_q;

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            second_q, second_d;
  logic [2:0]      samp_q, samp_d;
  logic [7:0]      data_q, data_d;
  logic            par_acc_q, par_acc_d;
  logic            zero_q, zero_d;
  logic            perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic            hold_q, hold_d;
  logic [1:0]      len_q, len_d;
  logic            nopar_q, nopar_d, ev_q, ev_d, stop2_q, stop2_d;
  logic            overrun_q, overrun_d;

  logic             push, pop, fifo_full, fifo_empty;
  logic             wrap, at_vote, vote, brk_now, ferr_now;
  logic [CW-1:0]    idx;
  logic [ENT_W-1:0] entry, head;

  // Synchroniser and tick detect run regardless of rx_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_last_q <= 1'b1;
      sclk_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
      sclk_q   <= sample_clk;
      tick_q   <= sample_clk & ~sclk_q;
      if (tick_q) rxd_last_q <= rxd_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      second_q  <= 1'b0;
      samp_q    <= '0;
      data_q    <= DATA_REG_DFT;
      par_acc_q <= 1'b0;
      zero_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      hold_q    <= 1'b0;
      len_q     <= '0;
      nopar_q   <= 1'b0;
      ev_q      <= 1'b0;
      stop2_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      second_q  <= second_d;
      samp_q    <= samp_d;
      data_q    <= data_d;
      par_acc_q <= par_acc_d;
      zero_q    <= zero_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      hold_q    <= hold_d;
      len_q     <= len_d;
      nopar_q   <= nopar_d;
      ev_q      <= ev_d;
      stop2_q   <= stop2_d;
      overrun_q <= overrun_d;
    end
  end

  assign wrap    = (cnt_q == CNT_MAX);
  assign idx     = cnt_q + CW'(1);
  assign at_vote = tick_q & ~wrap & (idx == SV);
  assign vote    = maj3(samp_q);
  assign pop     = rx_valid & rx_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    second_d  = second_q;
    samp_d    = samp_q;
    data_d    = data_q;
    par_acc_d = par_acc_q;
    zero_d    = zero_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;
    hold_d    = hold_q;
    len_d     = len_q;
    nopar_d   = nopar_q;
    ev_d      = ev_q;
    stop2_d   = stop2_q;
    overrun_d = overrun_q;
    push      = 1'b0;
    brk_now   = brk_q;
    ferr_now  = ferr_q;
    if (!rx_en) begin
      state_d   = RX_IDLE;
      cnt_d     = '0;
      bit_d     = '0;
      second_d  = 1'b0;
      hold_d    = 1'b0;
      overrun_d = 1'b0;
    end else if (tick_q) begin
      if (state_q != RX_IDLE) begin
        cnt_d = wrap ? '0 : idx;
        if (!wrap && idx == S0) samp_d[0] = rxd_s2_q;
        if (!wrap && idx == S1) samp_d[1] = rxd_s2_q;
        if (!wrap && idx == S2) samp_d[2] = rxd_s2_q;
      end
      unique case (state_q)
        RX_IDLE: begin
          if (hold_q) begin
            // After a break the line must stay high for a full bit before a new start.
            if (!rxd_s2_q) cnt_d = '0;
            else if (wrap) hold_d = 1'b0;
            else cnt_d = idx;
          end else if (rxd_last_q && !rxd_s2_q) begin
            state_d   = RX_START;
            cnt_d     = '0;
            bit_d     = '0;
            second_d  = 1'b0;
            data_d    = DATA_REG_DFT;
            par_acc_d = 1'b0;
            zero_d    = 1'b1;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
            brk_d     = 1'b0;
            len_d     = data_len;
            nopar_d   = no_parity;
            ev_d      = ev_parity;
            stop2_d   = stop2;
          end
        end
        RX_START: begin
          if (at_vote && vote) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
          end else if (wrap) begin
            state_d = RX_DATA;
          end
        end
        RX_DATA: begin
          if (at_vote) begin
            data_d[bit_q] = vote;
            par_acc_d     = par_acc_q ^ vote;
            zero_d        = zero_q & ~vote;
          end
          if (wrap) begin
            if (bit_q == {1'b0, len_q} + 3'd4) state_d = nopar_q ? RX_STOP : RX_PARITY;
            else bit_d = bit_q + 3'd1;
          end
        end
        RX_PARITY: begin
          if (at_vote) begin
            if (vote != (par_acc_q ^ ~ev_q)) perr_d = 1'b1;
            zero_d = zero_q & ~vote;
          end
          if (wrap) state_d = RX_STOP;
        end
        RX_STOP: begin
          if (at_vote) begin
            brk_now  = brk_q | (~second_q & zero_q & ~vote);
            ferr_now = ferr_q | ~vote | brk_now;
            brk_d    = brk_now;
            ferr_d   = ferr_now;
            if (stop2_q && !second_q) begin
              second_d = 1'b1;
            end else begin
              // Leave before the bit ends so the next start edge is never missed.
              push    = 1'b1;
              state_d = RX_IDLE;
              cnt_d   = '0;
              hold_d  = brk_now;
              if (fifo_full && !pop) overrun_d = 1'b1;
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    entry                   = '0;
    entry[ENT_DATA +: 8]    = data_q;
    entry[ENT_PAR]          = perr_q;
    entry[ENT_FRM]          = ferr_now;
    entry[ENT_BRK]          = brk_now;
  end

  uart_rx_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(~rx_en),
    .push (push),
    .wdata(entry),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign rx_valid   = ~fifo_empty;
  assign rx_data    = head[ENT_DATA +: 8];
  assign parity_err = head[ENT_PAR];
  assign frame_err  = head[ENT_FRM];
  assign break_det  = head[ENT_BRK];
  assign overrun    = overrun_q;

endmodule
